// File: rtl/pwm_duty_calculator.sv
// Three-phase signed voltage command to PWM on-cycle counts, optional min-max zero-sequence injection.
// One shared multiplier sequenced over the phases; accept to pwm_valid is 5 cycles, one command per 6 cycles.
module pwm_duty_calculator #(
  parameter int INPUT_WIDTH   = 16,
  parameter int DATA_WIDTH    = 16,
  parameter int PERIOD        = 3000,
  parameter int MAX_ON_CYCLES = 2980
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        fault,
  input  logic                        zsi_enable,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [3*INPUT_WIDTH-1:0]    in_data,
  output logic                        pwm_valid,
  output logic [3*DATA_WIDTH-1:0]     pwm_data,
  output logic [2:0]                  saturated
);

  localparam int W     = INPUT_WIDTH;
  localparam int PW    = $clog2(PERIOD + 1);
  localparam int PRODW = W + PW;

  typedef enum logic [2:0] {
    S_IDLE,
    S_OFFSET,
    S_MUL_U,
    S_MUL_V,
    S_MUL_W,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic signed [W-1:0]    cmd_u, cmd_v, cmd_w;
  logic                   zsi_q;
  logic        [W:0]      off;
  logic        [W:0]      off_nxt;
  logic signed [W-1:0]    mx, mn;
  logic        [W:0]      mm_sum;

  logic        [W-1:0]    x_sel;
  logic        [W:0]      d;
  logic        [W-1:0]    dc;
  logic                   sat_d;
  logic        [W-1:0]    p;
  logic        [PRODW-1:0] prod;
  logic        [PW-1:0]   c;
  logic        [PW-1:0]   c_cl;
  logic                   sat_m;
  logic [DATA_WIDTH-1:0]  phase_out;
  logic                   phase_sat;

  logic [DATA_WIDTH-1:0]  res_u, res_v;
  logic                   sat_u, sat_v;
  logic                   accept;

  assign in_ready  = (state == S_IDLE) & ~fault & ~reset;
  assign accept    = in_valid & in_ready;
  assign pwm_valid = (state == S_DONE) & ~fault;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (accept) state_nxt = S_OFFSET;
      S_OFFSET: state_nxt = S_MUL_U;
      S_MUL_U:  state_nxt = S_MUL_V;
      S_MUL_V:  state_nxt = S_MUL_W;
      S_MUL_W:  state_nxt = S_DONE;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
    if (fault) state_nxt = S_IDLE;
  end

  // Zero-sequence offset: floor((max + min) / 2) in W+1 bits.
  always_comb begin
    mx = cmd_u;
    if (cmd_v > mx) mx = cmd_v;
    if (cmd_w > mx) mx = cmd_w;
    mn = cmd_u;
    if (cmd_v < mn) mn = cmd_v;
    if (cmd_w < mn) mn = cmd_w;
    mm_sum  = {mx[W-1], mx} + {mn[W-1], mn};
    off_nxt = zsi_q ? {mm_sum[W], mm_sum[W:1]} : '0;
  end

  // Shared per-phase datapath; the phase is selected by the current state.
  always_comb begin
    case (state)
      S_MUL_U: x_sel = cmd_u;
      S_MUL_V: x_sel = cmd_v;
      default: x_sel = cmd_w;
    endcase
    d     = {x_sel[W-1], x_sel} - off;
    sat_d = 1'b0;
    dc    = d[W-1:0];
    if (d[W] != d[W-1]) begin
      sat_d = 1'b1;
      dc    = d[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end
    p     = {~dc[W-1], dc[W-2:0]};
    prod  = PRODW'(p) * PRODW'(PERIOD);
    c     = prod[PRODW-1:W];
    sat_m = 1'b0;
    c_cl  = c;
    if (c > PW'(MAX_ON_CYCLES)) begin
      sat_m = 1'b1;
      c_cl  = PW'(MAX_ON_CYCLES);
    end
    phase_out = DATA_WIDTH'(c_cl);
    phase_sat = sat_d | sat_m;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmd_u     <= '0;
      cmd_v     <= '0;
      cmd_w     <= '0;
      zsi_q     <= 1'b0;
      off       <= '0;
      res_u     <= '0;
      res_v     <= '0;
      sat_u     <= 1'b0;
      sat_v     <= 1'b0;
      pwm_data  <= '0;
      saturated <= '0;
    end else begin
      if (accept) begin
        cmd_u <= in_data[3*W-1:2*W];
        cmd_v <= in_data[2*W-1:W];
        cmd_w <= in_data[W-1:0];
        zsi_q <= zsi_enable;
      end
      if (state == S_OFFSET) off <= off_nxt;
      if (state == S_MUL_U) begin
        res_u <= phase_out;
        sat_u <= phase_sat;
      end
      if (state == S_MUL_V) begin
        res_v <= phase_out;
        sat_v <= phase_sat;
      end
      // Outputs only move on a run that reached the last phase without a fault.
      if (state == S_MUL_W && !fault) begin
        pwm_data  <= {res_u, res_v, phase_out};
        saturated <= {sat_u, sat_v, phase_sat};
      end
    end
  end

endmodule
